lfsr_rr_sched: RTL and testbench



---
 rtl/lfsr_rr_sched.sv | 136 +++++++++++++
 tb/tb_lfsr_rr_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rr_sched.sv
// Round-robin arbiter that shares one 16-bit Fibonacci LFSR among NUM_REQ requesters,
// stepping the LFSR STEPS_PER_WORD times per granted request and delivering the resulting word.
module lfsr_rr_sched #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned STEPS_PER_WORD = 16,
  parameter logic [15:0] RST_SEED       = 16'h1001
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rnd_valid,
  output logic [15:0]        rnd_data,
  input  logic               seed_load,
  input  logic [15:0]        seed_val,
  output logic               busy
);

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS_PER_WORD - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STEP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  winner_q, winner_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic              rnd_valid_q, rnd_valid_d;
  logic [LFSR_W-1:0] rnd_data_q, rnd_data_d;

  logic              rr_found_c;
  logic [IDX_W-1:0]  rr_idx_c;
  logic [LFSR_W-1:0] lfsr_shift_c;
  logic [LFSR_W-1:0] seed_safe_c;

  // x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
  assign lfsr_shift_c = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // A zero seed would lock the LFSR, so it is replaced by the reset seed
  assign seed_safe_c = (seed_val == '0) ? RST_SEED : seed_val;

  // Round-robin search starting just after the last served requester
  always_comb begin
    rr_found_c = 1'b0;
    rr_idx_c   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (!rr_found_c && req[IDX_W'((32'(last_q) + i) % NUM_REQ)]) begin
        rr_found_c = 1'b1;
        rr_idx_c   = IDX_W'((32'(last_q) + i) % NUM_REQ);
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    winner_d    = winner_q;
    last_d      = last_q;
    gnt_d       = '0;
    rnd_valid_d = 1'b0;
    rnd_data_d  = rnd_data_q;

    case (state_q)
      ST_IDLE: begin
        if (seed_load) begin
          lfsr_d = seed_safe_c;
        end else if (rr_found_c) begin
          winner_d = rr_idx_c;
          cnt_d    = '0;
          state_d  = ST_STEP;
        end
      end

      ST_STEP: begin
        lfsr_d = lfsr_shift_c;
        cnt_d  = cnt_q + CNT_W'(1);
        // A dropped request abandons the word but keeps the shifts already taken
        if (!req[winner_q]) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rnd_data_d       = lfsr_shift_c;
          gnt_d[winner_q]  = 1'b1;
          rnd_valid_d      = 1'b1;
          last_d           = winner_q;
          state_d          = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= RST_SEED;
      cnt_q       <= '0;
      winner_q    <= '0;
      last_q      <= LAST_RST;
      gnt_q       <= '0;
      rnd_valid_q <= 1'b0;
      rnd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      winner_q    <= winner_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_data_q  <= rnd_data_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd_valid = rnd_valid_q;
  assign rnd_data  = rnd_data_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Directed bench for lfsr_rr_sched with STEPS_PER_WORD=4 and hand-computed LFSR words.
module tb_lfsr_rr_sched;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        rnd_valid;
  logic [15:0] rnd_data;
  logic        seed_load;
  logic [15:0] seed_val;
  logic        busy;

  int total;
  int bad;

  lfsr_rr_sched #(
    .NUM_REQ(4),
    .STEPS_PER_WORD(4),
    .RST_SEED(16'h1001)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .gnt(gnt),
    .rnd_valid(rnd_valid),
    .rnd_data(rnd_data),
    .seed_load(seed_load),
    .seed_val(seed_val),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until rnd_valid is seen or the budget runs out; n is the number of ticks taken
  task automatic wait_gnt(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (rnd_valid !== 1'b1 && n < max);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_g [5];
    int n;

    total     = 0;
    bad       = 0;
    req       = '0;
    seed_load = 1'b0;
    seed_val  = '0;
    reset_n   = 1'b0;
    exp_g     = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset values
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(rnd_valid), 32'h0);
    chk("rst_data", 32'(rnd_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    tick();

    // Test 1: single requester, first word from reset seed
    req = 4'b0001;
    tick();
    chk("t1_busy_step", 32'(busy), 32'h1);
    chk("t1_no_early_gnt", 32'(gnt), 32'h0);
    wait_gnt(20, n);
    chk("t1_latency", 32'(n + 1), 32'd5);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_data", 32'(rnd_data), 32'h001D);
    chk("t1_busy_done", 32'(busy), 32'h1);

    // Test 2: held request, second word after a six-cycle period
    tick();
    chk("t2_gnt_pulse", 32'(gnt), 32'h0);
    chk("t2_valid_pulse", 32'(rnd_valid), 32'h0);
    chk("t2_data_hold", 32'(rnd_data), 32'h001D);
    chk("t2_busy_idle", 32'(busy), 32'h0);
    wait_gnt(20, n);
    chk("t2_period", 32'(n + 1), 32'd6);
    chk("t2_gnt", 32'(gnt), 32'h1);
    chk("t2_data", 32'(rnd_data), 32'h01D0);
    req = '0;
    tick();
    tick();

    // Test 3: all requesting, round-robin order
    reset_n = 1'b0;
    req = 4'b1111;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(20, n);
      chk($sformatf("t3_gnt%0d", k), 32'(gnt), 32'(exp_g[k]));
    end
    req = '0;
    tick();
    tick();

    // Test 4: zero seed substitution, seed beats request, seed ignored in STEP
    do_reset();
    seed_load = 1'b1;
    seed_val  = 16'h0000;
    req       = 4'b0001;
    tick();
    chk("t4_seed_stays_idle", 32'(busy), 32'h0);
    seed_load = 1'b0;
    wait_gnt(20, n);
    chk("t4_latency", 32'(n), 32'd5);
    chk("t4_zero_seed_data", 32'(rnd_data), 32'h001D);
    req = '0;
    tick();
    seed_load = 1'b1;
    seed_val  = 16'h8000;
    tick();
    seed_load = 1'b0;
    req = 4'b0001;
    tick();
    seed_load = 1'b1;
    seed_val  = 16'hFFFF;
    tick();
    seed_load = 1'b0;
    wait_gnt(20, n);
    chk("t4_seed8000_data", 32'(rnd_data), 32'h0008);
    chk("t4_seed8000_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();
    tick();

    // Test 5: abort after two STEP cycles, shifts are kept
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    tick();
    req = '0;
    tick();
    chk("t5_abort_idle", 32'(busy), 32'h0);
    chk("t5_abort_no_gnt", 32'(gnt), 32'h0);
    tick();
    tick();
    chk("t5_no_late_valid", 32'(rnd_valid), 32'h0);
    req = 4'b0100;
    wait_gnt(20, n);
    chk("t5_latency", 32'(n), 32'd5);
    chk("t5_gnt", 32'(gnt), 32'h4);
    chk("t5_data", 32'(rnd_data), 32'h00E8);
    req = '0;
    tick();
    tick();

    // Test 6: asynchronous reset mid-STEP discards the partial word
    req = 4'b0001;
    tick();
    tick();
    tick();
    chk("t6_busy_before", 32'(busy), 32'h1);
    chk("t6_data_before", 32'(rnd_data), 32'h00E8);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_gnt", 32'(gnt), 32'h0);
    chk("t6_async_valid", 32'(rnd_valid), 32'h0);
    chk("t6_async_data", 32'(rnd_data), 32'h0);
    chk("t6_async_busy", 32'(busy), 32'h0);
    tick();
    reset_n = 1'b1;
    wait_gnt(20, n);
    chk("t6_latency", 32'(n), 32'd5);
    chk("t6_data", 32'(rnd_data), 32'h001D);
    chk("t6_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
